// File: rtl/resilient_stage_seq.sv
// Self-timed pipeline stage controller with shadow-latch error recovery.
// Sequences left/right 4-phase handshakes around a sample/evaluate/recover window.
module resilient_stage_seq #(
  parameter int SAMPLE_CYCLES = 2,
  parameter int TIMEOUT       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Lreq,
  output logic       Lack,
  output logic       Rreq,
  input  logic       Rack,
  output logic       latch_en,
  output logic       sample,
  input  logic       Err0,
  input  logic       Err1,
  output logic       recover,
  output logic [7:0] err_cnt,
  output logic       fault,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SAMPLE,
    S_EVAL,
    S_RECOVER,
    S_OUTREQ,
    S_ACK
  } state_t;

  localparam logic [3:0] SAMP_LAST = 4'(SAMPLE_CYCLES - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [3:0] samp_cnt_reg, samp_cnt_next;
  logic [7:0] to_cnt_reg, to_cnt_next;
  logic [7:0] err_cnt_reg, err_cnt_next;
  logic       fault_reg, fault_next;
  logic [1:0] err_pair;

  assign err_pair = {Err1, Err0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      samp_cnt_reg <= '0;
      to_cnt_reg   <= '0;
      err_cnt_reg  <= '0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      samp_cnt_reg <= samp_cnt_next;
      to_cnt_reg   <= to_cnt_next;
      err_cnt_reg  <= err_cnt_next;
      fault_reg    <= fault_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    samp_cnt_next = samp_cnt_reg;
    to_cnt_next   = to_cnt_reg;
    err_cnt_next  = err_cnt_reg;
    fault_next    = fault_reg;

    case (state_reg)
      S_IDLE: begin
        if (Lreq) begin
          state_next    = S_CAPTURE;
          samp_cnt_next = '0;
          // Data rails must be at spacer when a new token is captured.
          if (err_pair != 2'b00) fault_next = 1'b1;
        end
      end
      S_CAPTURE: state_next = S_SAMPLE;
      S_SAMPLE: begin
        if (samp_cnt_reg == SAMP_LAST) begin
          state_next    = S_EVAL;
          samp_cnt_next = '0;
          to_cnt_next   = '0;
        end else begin
          samp_cnt_next = samp_cnt_reg + 4'd1;
        end
      end
      S_EVAL: begin
        case (err_pair)
          2'b01: begin
            state_next  = S_OUTREQ;
            to_cnt_next = '0;
          end
          2'b10: begin
            state_next  = S_RECOVER;
            to_cnt_next = '0;
          end
          2'b11: begin
            state_next  = S_RECOVER;
            to_cnt_next = '0;
            fault_next  = 1'b1;
          end
          default: begin
            // A stuck spacer is treated as an error, not a protocol fault.
            if (to_cnt_reg == TO_LAST) begin
              state_next  = S_RECOVER;
              to_cnt_next = '0;
            end else begin
              to_cnt_next = to_cnt_reg + 8'd1;
            end
          end
        endcase
      end
      S_RECOVER: begin
        state_next = S_OUTREQ;
        if (err_cnt_reg != 8'hFF) err_cnt_next = err_cnt_reg + 8'd1;
      end
      S_OUTREQ: begin
        if (Rack) state_next = S_ACK;
      end
      S_ACK: begin
        if (!Lreq && !Rack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Left side withdrew its request before being acknowledged.
    if ((state_reg == S_CAPTURE || state_reg == S_SAMPLE || state_reg == S_EVAL ||
         state_reg == S_RECOVER || state_reg == S_OUTREQ) && !Lreq)
      fault_next = 1'b1;

    // Right side acknowledged something it was never offered.
    if ((state_reg == S_IDLE || state_reg == S_CAPTURE || state_reg == S_SAMPLE ||
         state_reg == S_EVAL) && Rack)
      fault_next = 1'b1;
  end

  assign latch_en = (state_reg == S_CAPTURE) || (state_reg == S_RECOVER);
  assign sample   = (state_reg == S_SAMPLE);
  assign recover  = (state_reg == S_RECOVER);
  assign Rreq     = (state_reg == S_OUTREQ);
  assign Lack     = (state_reg == S_ACK);
  assign busy     = (state_reg != S_IDLE);
  assign err_cnt  = err_cnt_reg;
  assign fault    = fault_reg;

endmodule

// File: tb/tb_resilient_stage_seq.sv
// Directed bench for resilient_stage_seq: clean, error, timeout, illegal,
// protocol faults, asynchronous reset and counter saturation.
module tb_resilient_stage_seq;

  logic       clk, rst;
  logic       Lreq, Lack, Rreq, Rack;
  logic       latch_en, sample, Err0, Err1, recover, fault, busy;
  logic [7:0] err_cnt;
  int         total, bad;

  resilient_stage_seq dut (
    .clk(clk), .rst(rst), .Lreq(Lreq), .Lack(Lack), .Rreq(Rreq), .Rack(Rack),
    .latch_en(latch_en), .sample(sample), .Err0(Err0), .Err1(Err1),
    .recover(recover), .err_cnt(err_cnt), .fault(fault), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; Lreq = 1'b0; Rack = 1'b0; Err0 = 1'b0; Err1 = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Full transfer; {e1,e0} is presented during the first EVAL cycle.
  task automatic xfer(input logic e0, input logic e1);
    int n;
    Lreq = 1'b1; Err0 = 1'b0; Err1 = 1'b0;
    step(); step(); step();
    Err0 = e0; Err1 = e1;
    step(); step();
    Err0 = 1'b0; Err1 = 1'b0;
    n = 0;
    while (Rreq !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("xfer_rreq", Rreq, 1);
    Rack = 1'b1;
    step();
    Lreq = 1'b0; Rack = 1'b0;
    step();
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; Lreq = 1'b0; Rack = 1'b0; Err0 = 1'b0; Err1 = 1'b0;
    #2;
    chk("rst_outputs", {Lack, Rreq, latch_en, sample, recover, busy, fault}, 0);
    chk("rst_errcnt", err_cnt, 0);
    @(negedge clk); rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // Clean transfer
    Lreq = 1'b1;
    step();
    chk("clean_c1_latch", {latch_en, sample, busy}, 3'b101);
    step();
    chk("clean_c2_sample", {latch_en, sample}, 2'b01);
    step();
    chk("clean_c3_sample", sample, 1);
    Err0 = 1'b1;
    step();
    chk("clean_c4_eval", {sample, Rreq, latch_en, recover}, 0);
    step();
    chk("clean_c5_rreq", {Rreq, Lack, recover}, 3'b100);
    Err0 = 1'b0; Rack = 1'b1;
    step();
    chk("clean_ack", {Rreq, Lack}, 2'b01);
    Lreq = 1'b0; Rack = 1'b0;
    step();
    chk("clean_idle", {Lack, busy, fault}, 0);
    chk("clean_errcnt", err_cnt, 0);

    // Error transfer
    Lreq = 1'b1;
    step(); step(); step();
    Err1 = 1'b1;
    step();
    chk("err_eval", {Rreq, recover}, 0);
    step();
    chk("err_recover", {recover, latch_en, Rreq}, 3'b110);
    Err1 = 1'b0;
    step();
    chk("err_rreq_late", {Rreq, recover}, 2'b10);
    chk("err_errcnt", err_cnt, 1);
    Rack = 1'b1; step();
    Lreq = 1'b0; Rack = 1'b0; step();
    chk("err_fault", fault, 0);

    // Timeout: spacer held through EVAL
    Lreq = 1'b1;
    step(); step(); step();
    step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_eval%0d", i + 1), {busy, sample, recover, Rreq}, 4'b1000);
      step();
    end
    chk("to_recover", recover, 1);
    step();
    chk("to_errcnt", err_cnt, 2);
    chk("to_fault", fault, 0);
    Rack = 1'b1; step();
    Lreq = 1'b0; Rack = 1'b0; step();

    // Illegal 11 in EVAL
    Lreq = 1'b1;
    step(); step(); step();
    Err0 = 1'b1; Err1 = 1'b1;
    step(); step();
    chk("ill_recover", {recover, fault}, 2'b11);
    Err0 = 1'b0; Err1 = 1'b0;
    step();
    chk("ill_errcnt", err_cnt, 3);
    Rack = 1'b1; step();
    Lreq = 1'b0; Rack = 1'b0; step();

    // Asynchronous reset in SAMPLE, then a clean sequence
    Lreq = 1'b1;
    step(); step();
    chk("rstmid_in_sample", sample, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_async", {sample, busy, latch_en, fault}, 0);
    chk("rstmid_errcnt", err_cnt, 0);
    Lreq = 1'b0;
    @(negedge clk); rst = 1'b0;
    step();
    chk("rstmid_idle", busy, 0);
    Lreq = 1'b1;
    step();
    chk("post_c1", {latch_en, sample}, 2'b10);
    step(); step();
    chk("post_c3", sample, 1);
    Err0 = 1'b1;
    step(); step();
    chk("post_c5", Rreq, 1);
    Err0 = 1'b0; Rack = 1'b1; step();
    Lreq = 1'b0; Rack = 1'b0; step();
    chk("post_clean", {fault, err_cnt}, 0);

    // Non-spacer at CAPTURE entry
    Err0 = 1'b1; Lreq = 1'b1;
    step();
    chk("cap_fault", fault, 1);
    do_reset();

    // Rack while idle
    Rack = 1'b1;
    step();
    chk("rack_idle_fault", {fault, busy}, 2'b10);
    do_reset();
    chk("fault_cleared", fault, 0);

    // Lreq dropped early: fault, sequence continues
    Lreq = 1'b1; step();
    Lreq = 1'b0; step();
    chk("early_drop", {fault, sample}, 2'b11);
    do_reset();

    // Saturation
    for (int i = 0; i < 260; i++) xfer(1'b0, 1'b1);
    chk("sat_errcnt", err_cnt, 255);
    chk("sat_fault", fault, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
